fft_out_streamer: RTL and testbench

//  Reader side of the 32-point radix-2 DIT butterfly datapath.
//  - Captures one parallel frame of complex FFT words (N x W bits) via a valid/ready handshake.
//  - Streams the frame out one complex word per beat on a valid/ready stream.
//  - Optionally undoes the bit-reversed slot ordering so bins leave in natural order.
//  - Sits between the butterfly stage outputs and downstream serial consumers (magnitude, UART, capture).

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_bitrev_idx.sv | 15 +
 rtl/fft_out_streamer.sv | 98 +++++++++
 tb/tb_fft_out_streamer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, complex word layout and the bit-reversal helper.
// Combinational helpers only; no latency.
// No flow control here; the function also drives the stage-1 input permutation.
package fft_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_W     = 16;
    localparam int FFT_LOG2N = $clog2(FFT_N);

    typedef struct packed {
        logic [FFT_W/2-1:0] im;
        logic [FFT_W/2-1:0] re;
    } cplx_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } strm_state_t;

    // Reverses the low nbits of idx; bits above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < nbits) r[nbits-1-b] = idx[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_idx.sv
// Maps an output bin index to its bit-reversed buffer slot.
// Purely combinational, zero latency.
// No flow control.
module fft_bitrev_idx
    import fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic [LOG2N-1:0] i_idx,
    output logic [LOG2N-1:0] o_slot
);

    assign o_slot = LOG2N'(bitrev(32'(i_idx), LOG2N));

endmodule

// File: rtl/fft_out_streamer.sv
// Captures a parallel FFT frame and streams it out one complex word per beat.
// First beat valid the cycle after capture; N_POINTS beats per frame minimum.
// Holds the beat under m_ready low; a new frame is accepted only when idle or on the last beat.
module fft_out_streamer
    import fft_pkg::*;
#(
    parameter int N_POINTS = FFT_N,
    parameter int W        = FFT_W,
    parameter int BITREV   = 1,
    parameter int LOG2N    = $clog2(N_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_POINTS*W-1:0] frame_in,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic [W-1:0]          m_data,
    output logic [W/2-1:0]        m_re,
    output logic [W/2-1:0]        m_im,
    output logic [LOG2N-1:0]      m_index,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [7:0]            frames_sent
);

    strm_state_t           r_state;
    strm_state_t           w_state_nxt;
    logic [LOG2N-1:0]      r_idx;
    logic [LOG2N-1:0]      w_slot;
    logic [N_POINTS*W-1:0] r_buf;
    logic [7:0]            r_frames;
    logic                  w_is_last;
    logic                  w_beat;
    logic                  w_capture;

    assign w_is_last = (r_state == ST_STREAM) && (r_idx == LOG2N'(N_POINTS-1));
    assign w_beat    = m_valid & m_ready;
    assign w_capture = frame_valid & frame_ready;

    generate
        if (BITREV != 0) begin : g_bitrev
            fft_bitrev_idx #(.LOG2N(LOG2N)) u_bitrev (
                .i_idx  (r_idx),
                .o_slot (w_slot)
            );
        end else begin : g_natural
            assign w_slot = r_idx;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_capture) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_beat && w_is_last) w_state_nxt = w_capture ? ST_STREAM : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // The last beat doubles as the only mid-stream accept point, so frames chain without bubbles.
    always_comb begin
        frame_ready = 1'b0;
        m_valid     = 1'b0;
        if (!rst) begin
            frame_ready = (r_state == ST_IDLE) || (w_is_last && m_ready);
        end
        if (r_state == ST_STREAM) m_valid = 1'b1;
    end

    assign m_last      = w_is_last;
    assign m_index     = r_idx;
    assign m_data      = r_buf[w_slot*W +: W];
    assign m_re        = m_data[W/2-1:0];
    assign m_im        = m_data[W-1:W/2];
    assign frames_sent = r_frames;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_frames <= '0;
        end else begin
            if (w_capture)                 r_idx <= '0;
            else if (w_beat && !w_is_last) r_idx <= r_idx + 1'b1;
            if (w_beat && w_is_last)       r_frames <= r_frames + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) r_buf <= frame_in;
    end

endmodule

// File: tb/tb_fft_out_streamer.sv
// Drives a bit-reversed and a natural-order streamer and scores every cycle against a frame-level model.
// Directed phases cover reset, ordering, backpressure, chaining and mid-stream reset; a random phase wraps the frame counter.
module tb_fft_out_streamer;
    import fft_pkg::*;

    logic         clk = 1'b0;
    logic         rst  [2];
    logic [511:0] fin  [2];
    logic         fv   [2];
    logic         frdy [2];
    logic [15:0]  md   [2];
    logic [7:0]   mre  [2];
    logic [7:0]   mim  [2];
    logic [4:0]   mix  [2];
    logic         mv   [2];
    logic         mr   [2];
    logic         ml   [2];
    logic [7:0]   fs   [2];

    int checks   = 0;
    int failures = 0;

    logic [15:0] mf  [2][32];
    int          pos [2];
    bit          act [2];
    int          cnt [2];

    logic  m_er;
    cplx_t m_ew;
    int    m_sl;

    always #5 clk = ~clk;

    fft_out_streamer #(.N_POINTS(32), .W(16), .BITREV(1)) u_rev (
        .clk(clk), .rst(rst[0]), .frame_in(fin[0]), .frame_valid(fv[0]), .frame_ready(frdy[0]),
        .m_data(md[0]), .m_re(mre[0]), .m_im(mim[0]), .m_index(mix[0]), .m_valid(mv[0]),
        .m_ready(mr[0]), .m_last(ml[0]), .frames_sent(fs[0])
    );

    fft_out_streamer #(.N_POINTS(32), .W(16), .BITREV(0)) u_nat (
        .clk(clk), .rst(rst[1]), .frame_in(fin[1]), .frame_valid(fv[1]), .frame_ready(frdy[1]),
        .m_data(md[1]), .m_re(mre[1]), .m_im(mim[1]), .m_index(mix[1]), .m_valid(mv[1]),
        .m_ready(mr[1]), .m_last(ml[1]), .frames_sent(fs[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rev5(input int k);
        int r = 0;
        int v = k;
        for (int i = 0; i < 5; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    // Model: a stream holds one captured frame and the beat number within it.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_er = !rst[u] && (!act[u] || (pos[u] == 31 && mr[u]));
            chk($sformatf("u%0d m_valid", u), 32'(mv[u]), 32'(act[u]));
            chk($sformatf("u%0d frame_ready", u), 32'(frdy[u]), 32'(m_er));
            chk($sformatf("u%0d frames_sent", u), 32'(fs[u]), 32'(cnt[u] % 256));
            if (act[u]) begin
                m_sl = (u == 0) ? rev5(pos[u]) : pos[u];
                m_ew = mf[u][m_sl];
                chk($sformatf("u%0d m_index", u), 32'(mix[u]), 32'(pos[u]));
                chk($sformatf("u%0d m_data k=%0d", u, pos[u]), 32'(md[u]), 32'(m_ew));
                chk($sformatf("u%0d m_re", u), 32'(mre[u]), 32'(m_ew.re));
                chk($sformatf("u%0d m_im", u), 32'(mim[u]), 32'(m_ew.im));
                chk($sformatf("u%0d m_last", u), 32'(ml[u]), 32'(pos[u] == 31));
            end
            if (rst[u]) begin
                act[u] = 1'b0;
                pos[u] = 0;
                cnt[u] = 0;
            end else begin
                if (act[u] && mr[u]) begin
                    if (pos[u] == 31) begin
                        cnt[u]++;
                        act[u] = 1'b0;
                    end else begin
                        pos[u]++;
                    end
                end
                if (fv[u] && m_er) begin
                    for (int s = 0; s < 32; s++) mf[u][s] = fin[u][s*16 +: 16];
                    act[u] = 1'b1;
                    pos[u] = 0;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int u, input int k);
        int n = 0;
        while (!(mv[u] && 32'(mix[u]) == 32'(k))) begin
            cycle();
            n++;
            if (n > 200) begin
                chk($sformatf("u%0d wait_idx%0d timeout", u, k), 32'd1, 32'd0);
                return;
            end
        end
    endtask

    function automatic logic [511:0] rand_frame();
        logic [511:0] f;
        for (int s = 0; s < 16; s++) f[s*32 +: 32] = $urandom;
        return f;
    endfunction

    initial begin
        int ncyc;
        int held;
        int n;
        logic [7:0] sb;
        for (int u = 0; u < 2; u++) begin
            act[u] = 1'b0; pos[u] = 0; cnt[u] = 0;
            rst[u] = 1'b1; fv[u] = 1'b0; mr[u] = 1'b1; fin[u] = '0;
        end

        // Reset: two cycles, then idle and ready.
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        chk("rst frame_ready", 32'(frdy[0]), 32'd1);
        chk("rst m_valid", 32'(mv[0]), 32'd0);
        chk("rst frames_sent", 32'(fs[0]), 32'd0);

        // Bit-reversed order with a recognisable slot pattern.
        for (int s = 0; s < 32; s++) begin
            sb = s[7:0];
            fin[0][s*16 +: 16] = {sb, ~sb};
        end
        fv[0] = 1'b1;
        cycle();
        fv[0] = 1'b0;
        chk("first beat index", 32'(mix[0]), 32'd0);
        wait_idx(0, 1);
        chk("beat1 data slot16", 32'(md[0]), 32'h10EF);
        wait_idx(0, 31);
        chk("beat31 data", 32'(md[0]), 32'h1FE0);
        chk("beat31 last", 32'(ml[0]), 32'd1);
        cycle();
        chk("frame1 frames_sent", 32'(fs[0]), 32'd1);
        chk("frame1 idle", 32'(mv[0]), 32'd0);

        // Backpressure: three stalled cycles at index 5.
        fin[0] = rand_frame();
        fv[0] = 1'b1;
        cycle();
        fv[0] = 1'b0;
        ncyc = 0;
        held = 0;
        n = 0;
        while (n < 100) begin
            if (mv[0]) ncyc++;
            if (mv[0] && mix[0] == 5'd5 && held < 3) begin
                mr[0] = 1'b0;
                held++;
            end else begin
                mr[0] = 1'b1;
            end
            if (mv[0] && ml[0] && mr[0]) n = 1000;
            cycle();
            n++;
        end
        chk("bp frame cycles", 32'(ncyc), 32'd35);
        chk("bp frames_sent", 32'(fs[0]), 32'd2);

        // Back-to-back frames with frame_valid held.
        fin[0] = rand_frame();
        fv[0] = 1'b1;
        cycle();
        fin[0] = rand_frame();
        wait_idx(0, 31);
        cycle();
        chk("b2b no bubble valid", 32'(mv[0]), 32'd1);
        chk("b2b restart index", 32'(mix[0]), 32'd0);
        chk("b2b frames_sent", 32'(fs[0]), 32'd3);
        fv[0] = 1'b0;
        wait_idx(0, 31);
        cycle();
        chk("b2b second done", 32'(fs[0]), 32'd4);

        // Mid-stream reset aborts the frame.
        fin[0] = rand_frame();
        fv[0] = 1'b1;
        cycle();
        fv[0] = 1'b0;
        wait_idx(0, 10);
        rst[0] = 1'b1;
        #1;
        chk("midrst frame_ready", 32'(frdy[0]), 32'd0);
        cycle();
        chk("midrst m_valid", 32'(mv[0]), 32'd0);
        chk("midrst m_last", 32'(ml[0]), 32'd0);
        chk("midrst frames_sent", 32'(fs[0]), 32'd0);
        rst[0] = 1'b0;

        // Random traffic on both; natural-order stream runs until its counter wraps.
        n = 0;
        while (cnt[1] < 256 && n < 40000) begin
            for (int u = 0; u < 2; u++) begin
                fin[u] = rand_frame();
                fv[u]  = ($urandom % 4) != 0;
                mr[u]  = ($urandom % 4) != 0;
            end
            cycle();
            n++;
        end
        if (n >= 40000) chk("wrap timeout", 32'd1, 32'd0);
        chk("wrap frames_sent", 32'(fs[1]), 32'd0);
        fv[0] = 1'b0;
        fv[1] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
